// File: rtl/turfio_seq_defs.sv
`default_nettype none
// ============================================================================
// turfio_seq_defs : state encodings and field widths for the TURFIO link
//                   sequencer, shared with the PS register-map decode.
// Revision 1.0
// ============================================================================
package turfio_seq_defs;

    localparam int c_STATE_W = 3;
    localparam int c_FAIL_W  = 8;

    localparam logic [c_STATE_W-1:0] c_ST_PMA_INIT   = 3'd0;
    localparam logic [c_STATE_W-1:0] c_ST_PLL_WAIT   = 3'd1;
    localparam logic [c_STATE_W-1:0] c_ST_SCAN       = 3'd2;
    localparam logic [c_STATE_W-1:0] c_ST_LINK_RESET = 3'd3;
    localparam logic [c_STATE_W-1:0] c_ST_LINK_WAIT  = 3'd4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_timer.sv
`default_nettype none
// ============================================================================
// seq_timer : loadable down-counter that holds at zero.
// Revision 1.0
// ============================================================================
module seq_timer #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= RESET_VALUE;
        end else if (load_i) begin
            r_count <= value_i;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero_o = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/turfio_link_sequencer.sv
`default_nettype none
// ============================================================================
// turfio_link_sequencer : PMA/PLL bring-up and round-robin recovery of the
//                         TURFIO Aurora links, with saturating failure counts.
// Revision 1.0
// ============================================================================
module turfio_link_sequencer
    import turfio_seq_defs::*;
#(
    parameter int NUM_LINKS       = 4,
    parameter int PMA_INIT_CYCLES = 100000000,
    parameter int RESET_PB_CYCLES = 128,
    parameter int LOCK_TIMEOUT    = 10000000,
    parameter int PLL_TIMEOUT     = 1000000
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_LINKS-1:0]            enable_i,
    input  logic                            force_reset_i,
    input  logic                            gt_pll_lock_i,
    input  logic [NUM_LINKS-1:0]            channel_up_i,
    output logic                            pma_init_o,
    output logic [NUM_LINKS-1:0]            reset_pb_o,
    output logic [NUM_LINKS-1:0]            link_ok_o,
    output logic                            busy_o,
    output logic [c_STATE_W-1:0]            state_o,
    output logic [c_FAIL_W*NUM_LINKS-1:0]   fail_count_o
);

    localparam int c_MAX_CYCLES = max_int(max_int(PMA_INIT_CYCLES, RESET_PB_CYCLES),
                                          max_int(LOCK_TIMEOUT, PLL_TIMEOUT));
    localparam int c_TMR_W = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;
    localparam int c_SEL_W = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;

    localparam logic [c_TMR_W-1:0] c_LD_PMA  = c_TMR_W'(PMA_INIT_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_LD_PLL  = c_TMR_W'(PLL_TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_LD_RPB  = c_TMR_W'(RESET_PB_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_LD_LOCK = c_TMR_W'(LOCK_TIMEOUT - 1);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next;
    logic [c_SEL_W-1:0]   r_sel;
    logic [c_SEL_W-1:0]   w_sel_next;
    logic [c_SEL_W-1:0]   w_pick;
    logic [c_SEL_W-1:0]   w_idx;
    logic                 w_found;
    logic                 w_tmr_load;
    logic [c_TMR_W-1:0]   w_tmr_value;
    logic                 w_tmr_zero;
    logic                 w_fail_inc;
    logic                 w_in_link_state;
    logic [NUM_LINKS-1:0] w_down;

    logic                 w_pma;
    logic [NUM_LINKS-1:0] w_rpb;
    logic                 w_busy;

    logic                 r_pma;
    logic [NUM_LINKS-1:0] r_rpb;
    logic [NUM_LINKS-1:0] r_link_ok;
    logic                 r_busy;
    logic [c_STATE_W-1:0] r_state_dbg;
    logic [c_FAIL_W-1:0]  r_fail [NUM_LINKS];

    seq_timer #(
        .WIDTH       (c_TMR_W),
        .RESET_VALUE (c_LD_PMA)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (w_tmr_load),
        .value_i (w_tmr_value),
        .zero_o  (w_tmr_zero)
    );

    assign w_down          = enable_i & ~channel_up_i;
    assign w_in_link_state = (r_state == c_ST_SCAN) || (r_state == c_ST_LINK_RESET) ||
                             (r_state == c_ST_LINK_WAIT);

    // Walk offsets from farthest to nearest so the link just after r_sel wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_sel;
        w_idx   = r_sel;
        for (int k = NUM_LINKS; k >= 1; k--) begin
            w_idx = c_SEL_W'((int'(r_sel) + k) % NUM_LINKS);
            if (w_down[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_ST_PMA_INIT;
            r_sel   <= '0;
        end else begin
            r_state <= w_next;
            r_sel   <= w_sel_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_sel_next  = r_sel;
        w_fail_inc  = 1'b0;
        w_tmr_value = '0;
        if (force_reset_i || (!gt_pll_lock_i && w_in_link_state)) begin
            w_next = c_ST_PMA_INIT;
        end else begin
            case (r_state)
                c_ST_PMA_INIT: begin
                    if (w_tmr_zero) w_next = c_ST_PLL_WAIT;
                end
                c_ST_PLL_WAIT: begin
                    if (gt_pll_lock_i)   w_next = c_ST_SCAN;
                    else if (w_tmr_zero) w_next = c_ST_PMA_INIT;
                end
                c_ST_SCAN: begin
                    if (w_found) begin
                        w_next     = c_ST_LINK_RESET;
                        w_sel_next = w_pick;
                    end
                end
                c_ST_LINK_RESET: begin
                    if (!enable_i[r_sel]) w_next = c_ST_SCAN;
                    else if (w_tmr_zero)  w_next = c_ST_LINK_WAIT;
                end
                c_ST_LINK_WAIT: begin
                    // A link coming up on the final count is still a success.
                    if (!enable_i[r_sel] || channel_up_i[r_sel]) begin
                        w_next = c_ST_SCAN;
                    end else if (w_tmr_zero) begin
                        w_next     = c_ST_SCAN;
                        w_fail_inc = 1'b1;
                    end
                end
                default: w_next = c_ST_PMA_INIT;
            endcase
        end
        w_tmr_load = force_reset_i || (w_next != r_state);
        case (w_next)
            c_ST_PMA_INIT:   w_tmr_value = c_LD_PMA;
            c_ST_PLL_WAIT:   w_tmr_value = c_LD_PLL;
            c_ST_LINK_RESET: w_tmr_value = c_LD_RPB;
            c_ST_LINK_WAIT:  w_tmr_value = c_LD_LOCK;
            default:         w_tmr_value = '0;
        endcase
    end

    always_comb begin
        w_pma  = 1'b0;
        w_rpb  = '0;
        w_busy = 1'b1;
        case (r_state)
            c_ST_PMA_INIT: begin
                w_pma = 1'b1;
                w_rpb = '1;
            end
            c_ST_PLL_WAIT:   w_rpb = '1;
            c_ST_SCAN:       w_busy = 1'b0;
            c_ST_LINK_RESET: w_rpb[r_sel] = 1'b1;
            default:         w_busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pma       <= 1'b1;
            r_rpb       <= '1;
            r_link_ok   <= '0;
            r_busy      <= 1'b1;
            r_state_dbg <= c_ST_PMA_INIT;
        end else begin
            r_pma       <= w_pma;
            r_rpb       <= w_rpb;
            r_link_ok   <= enable_i & channel_up_i;
            r_busy      <= w_busy;
            r_state_dbg <= r_state;
        end
    end

    // Only rst_i clears the counts; a forced PMA restart keeps the history.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_LINKS; i++) r_fail[i] <= '0;
        end else if (w_fail_inc && (r_fail[r_sel] != {c_FAIL_W{1'b1}})) begin
            r_fail[r_sel] <= r_fail[r_sel] + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LINKS; gi++) begin : g_fail_pack
            assign fail_count_o[gi*c_FAIL_W +: c_FAIL_W] = r_fail[gi];
        end
    endgenerate

    assign pma_init_o = r_pma;
    assign reset_pb_o = r_rpb;
    assign link_ok_o  = r_link_ok;
    assign busy_o     = r_busy;
    assign state_o    = r_state_dbg;

endmodule
`default_nettype wire
